// File: rtl/datapath_sequencer.sv
// Program sequencer for the 4-bit three-register datapath: fetches 8-bit instructions from a
// 16-entry ROM and drives the registered control bus one phase per clock.
module datapath_sequencer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       STEP_MODE,
  input  logic       STEP,
  input  logic [7:0] INSTR,
  output logic [3:0] PC,
  output logic       CLR,
  output logic [2:0] W,
  output logic [3:0] CE,
  output logic [1:0] SEL,
  output logic [2:0] S,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [2:0] {
    StIdle, StInit, StFetch, StDecode, StLoad, StExec, StPause, StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [2:0]  start_sync_q, start_sync_d;
  logic [2:0]  step_sync_q, step_sync_d;
  logic        clr_q, clr_d;
  logic [2:0]  w_q, w_d;
  logic [3:0]  ce_q, ce_d;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  s_q, s_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_edge, step_edge, advance;

  // Bits [1:0] synchronise, bit [2] holds the previous synchronised level for edge detection.
  assign start_sync_d = {start_sync_q[1:0], START};
  assign step_sync_d  = {step_sync_q[1:0], STEP};
  assign start_edge   = start_sync_q[1] & ~start_sync_q[2];
  assign step_edge    = step_sync_q[1] & ~step_sync_q[2];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    advance = 1'b0;
    case (state_q)
      StIdle, StHalt: if (start_edge) state_d = StInit;
      StInit: begin
        pc_d    = 4'd0;
        state_d = StFetch;
      end
      StFetch: begin
        ir_d    = INSTR;
        state_d = StDecode;
      end
      StDecode: begin
        if (ir_q[2:1] == 2'b11) begin
          if (ir_q[7:5] == 3'b000) state_d = StHalt;
          else                     advance = 1'b1;
        end else begin
          state_d = ir_q[0] ? StLoad : StExec;
        end
      end
      StLoad:  state_d = StExec;
      StExec:  advance = 1'b1;
      StPause: if (step_edge) state_d = StFetch;
      default: state_d = StIdle;
    endcase
    if (advance) begin
      pc_d    = pc_q + 4'd1;
      state_d = STEP_MODE ? StPause : StFetch;
    end
  end

  // Outputs are registered, so they are decoded from the state and IR being entered.
  always_comb begin
    clr_d = 1'b0;
    w_d   = 3'b000;
    ce_d  = 4'b0000;
    sel_d = 2'b00;
    s_d   = 3'b000;
    case (state_d)
      StInit: begin
        clr_d = 1'b1;
        w_d   = 3'b100;
      end
      StDecode: begin
        if (ir_d[2:1] == 2'b11 && ir_d[7:5] == 3'b001) begin
          clr_d = 1'b1;
          w_d   = 3'b100;
        end
      end
      StLoad: begin
        sel_d = ir_d[4:3];
        ce_d  = 4'b1000;
        w_d   = 3'b010;
      end
      StExec: begin
        sel_d = ir_d[0] ? 2'b11 : ir_d[4:3];
        s_d   = ir_d[7:5];
        w_d   = 3'b001;
        ce_d  = 4'b0001 << ir_d[2:1];
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle) && (state_d != StHalt);
    done_d = (state_d == StHalt);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      pc_q         <= 4'd0;
      ir_q         <= 8'h00;
      start_sync_q <= 3'b000;
      step_sync_q  <= 3'b000;
      clr_q        <= 1'b0;
      w_q          <= 3'b000;
      ce_q         <= 4'b0000;
      sel_q        <= 2'b00;
      s_q          <= 3'b000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      start_sync_q <= start_sync_d;
      step_sync_q  <= step_sync_d;
      clr_q        <= clr_d;
      w_q          <= w_d;
      ce_q         <= ce_d;
      sel_q        <= sel_d;
      s_q          <= s_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign PC   = pc_q;
  assign CLR  = clr_q;
  assign W    = w_q;
  assign CE   = ce_q;
  assign SEL  = sel_q;
  assign S    = s_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
